// File: rtl/score_keeper_pkg.sv
// Shared pong definitions: game state encoding and the score/pause defaults
// used by the score keeper, display controller and physics block.
package score_keeper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

    typedef logic [2:0] score_t;

    localparam score_t      DEF_MAX_SCORE    = 3'd7;
    localparam int unsigned DEF_PW           = 32'd8;
    localparam logic [7:0]  DEF_PAUSE_FRAMES = 8'd60;

    // Scores stop at MAX_SCORE because the game ends there, so no wrap handling.
    function automatic score_t score_inc(input score_t s);
        return s + 3'd1;
    endfunction

endpackage

// File: rtl/score_keeper_edge_detect.sv
// Single-bit rising-edge detector: the pulse is the live input against a
// registered copy, so a level held for many cycles yields one pulse.
module score_keeper_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic d_r;

    // Delayed copy of the input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_r <= 1'b0;
        end else begin
            d_r <= d;
        end
    end

    assign rise = d & ~d_r;

endmodule

// File: rtl/score_keeper.sv
// Game-score sequencer: latches goal events, applies them on frame ticks,
// runs the serve pause and game-over sequencing for the two pip displays.
module score_keeper
    import score_keeper_pkg::*;
#(
    parameter score_t      MAX_SCORE    = DEF_MAX_SCORE,
    parameter int unsigned PW           = DEF_PW,
    parameter logic [PW-1:0] PAUSE_FRAMES = DEF_PAUSE_FRAMES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       goal_l,
    input  logic       goal_r,
    input  logic       start_btn,
    output logic [2:0] score_l,
    output logic [2:0] score_r,
    output logic       ball_freeze,
    output logic       serve_dir,
    output logic       game_over,
    output logic       winner
);

    localparam logic [PW-1:0] CNT_ONE  = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] CNT_ZERO = {PW{1'b0}};

    state_e        state_r;
    logic [PW-1:0] pause_cnt_r;
    logic          pend_l_r;
    logic          pend_r_r;

    logic   rise_l_s;
    logic   rise_r_s;
    logic   rise_start_s;
    logic   pend_l_nxt_s;
    logic   pend_r_nxt_s;
    score_t score_l_inc_s;
    score_t score_r_inc_s;

    score_keeper_edge_detect u_edge_goal_l (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (goal_l),
        .rise  (rise_l_s)
    );

    score_keeper_edge_detect u_edge_goal_r (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (goal_r),
        .rise  (rise_r_s)
    );

    score_keeper_edge_detect u_edge_start (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (start_btn),
        .rise  (rise_start_s)
    );

    // Pending-goal capture: first event wins, left beats right on a tie.
    always_comb begin
        pend_l_nxt_s = pend_l_r;
        pend_r_nxt_s = pend_r_r;
        if ((state_r == ST_PLAY) && !pend_l_r && !pend_r_r) begin
            if (rise_l_s) begin
                pend_l_nxt_s = 1'b1;
            end else if (rise_r_s) begin
                pend_r_nxt_s = 1'b1;
            end else begin
                pend_l_nxt_s = 1'b0;
                pend_r_nxt_s = 1'b0;
            end
        end else begin
            pend_l_nxt_s = pend_l_r;
            pend_r_nxt_s = pend_r_r;
        end
    end

    assign score_l_inc_s = score_inc(score_l);
    assign score_r_inc_s = score_inc(score_r);

    // Game FSM with registered outputs; score changes only land on frame ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            pause_cnt_r <= CNT_ZERO;
            pend_l_r    <= 1'b0;
            pend_r_r    <= 1'b0;
            score_l     <= 3'd0;
            score_r     <= 3'd0;
            ball_freeze <= 1'b1;
            serve_dir   <= 1'b0;
            game_over   <= 1'b0;
            winner      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    score_l     <= 3'd0;
                    score_r     <= 3'd0;
                    pend_l_r    <= 1'b0;
                    pend_r_r    <= 1'b0;
                    if (rise_start_s) begin
                        state_r     <= ST_PLAY;
                        ball_freeze <= 1'b0;
                    end else begin
                        ball_freeze <= 1'b1;
                    end
                end

                ST_PLAY: begin
                    if (frame_tick && pend_l_nxt_s) begin
                        score_l     <= score_l_inc_s;
                        pend_l_r    <= 1'b0;
                        pend_r_r    <= 1'b0;
                        ball_freeze <= 1'b1;
                        serve_dir   <= 1'b0;
                        if (score_l_inc_s == MAX_SCORE) begin
                            state_r   <= ST_OVER;
                            game_over <= 1'b1;
                            winner    <= 1'b1;
                        end else begin
                            state_r     <= ST_PAUSE;
                            pause_cnt_r <= PAUSE_FRAMES;
                        end
                    end else if (frame_tick && pend_r_nxt_s) begin
                        score_r     <= score_r_inc_s;
                        pend_l_r    <= 1'b0;
                        pend_r_r    <= 1'b0;
                        ball_freeze <= 1'b1;
                        serve_dir   <= 1'b1;
                        if (score_r_inc_s == MAX_SCORE) begin
                            state_r   <= ST_OVER;
                            game_over <= 1'b1;
                            winner    <= 1'b0;
                        end else begin
                            state_r     <= ST_PAUSE;
                            pause_cnt_r <= PAUSE_FRAMES;
                        end
                    end else begin
                        pend_l_r <= pend_l_nxt_s;
                        pend_r_r <= pend_r_nxt_s;
                    end
                end

                ST_PAUSE: begin
                    pend_l_r <= 1'b0;
                    pend_r_r <= 1'b0;
                    if (frame_tick) begin
                        pause_cnt_r <= pause_cnt_r - CNT_ONE;
                        if (pause_cnt_r == CNT_ONE) begin
                            state_r     <= ST_PLAY;
                            ball_freeze <= 1'b0;
                        end else begin
                            ball_freeze <= 1'b1;
                        end
                    end else begin
                        pause_cnt_r <= pause_cnt_r;
                    end
                end

                ST_OVER: begin
                    ball_freeze <= 1'b1;
                    pend_l_r    <= 1'b0;
                    pend_r_r    <= 1'b0;
                    if (rise_start_s) begin
                        state_r   <= ST_IDLE;
                        score_l   <= 3'd0;
                        score_r   <= 3'd0;
                        game_over <= 1'b0;
                        winner    <= 1'b0;
                    end else begin
                        game_over <= 1'b1;
                    end
                end

                default: begin
                    state_r     <= ST_IDLE;
                    ball_freeze <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: a game-level reference model checked every
// cycle, plus hand-computed literal checks at the key points of a game.
module tb_score_keeper;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       frame_tick = 1'b0;
    logic       goal_l = 1'b0;
    logic       goal_r = 1'b0;
    logic       start_btn = 1'b0;
    logic [2:0] score_l;
    logic [2:0] score_r;
    logic       ball_freeze;
    logic       serve_dir;
    logic       game_over;
    logic       winner;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    score_keeper dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_tick  (frame_tick),
        .goal_l      (goal_l),
        .goal_r      (goal_r),
        .start_btn   (start_btn),
        .score_l     (score_l),
        .score_r     (score_r),
        .ball_freeze (ball_freeze),
        .serve_dir   (serve_dir),
        .game_over   (game_over),
        .winner      (winner)
    );

    always #5 clk = ~clk;

    // Game-level reference model: modes as names, scores as plain integers.
    localparam int M_IDLE = 0, M_PLAY = 1, M_PAUSE = 2, M_OVER = 3;
    int m_mode = M_IDLE;
    int m_sl = 0, m_sr = 0, m_pause = 0;
    int m_who = 0;                 // 0 none, 1 left conceded, 2 right conceded
    int m_freeze = 1, m_dir = 0, m_over = 0, m_win = 0;
    int h_gl = 0, h_gr = 0, h_st = 0;
    int e_gl, e_gr, e_st;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = M_IDLE; m_sl = 0; m_sr = 0; m_pause = 0; m_who = 0;
            m_freeze = 1; m_dir = 0; m_over = 0; m_win = 0;
            h_gl = 0; h_gr = 0; h_st = 0;
        end else begin
            e_gl = (goal_l && !h_gl) ? 1 : 0;
            e_gr = (goal_r && !h_gr) ? 1 : 0;
            e_st = (start_btn && !h_st) ? 1 : 0;
            h_gl = goal_l; h_gr = goal_r; h_st = start_btn;
            if (m_mode == M_IDLE) begin
                if (e_st) begin m_mode = M_PLAY; m_freeze = 0; end
            end else if (m_mode == M_PLAY) begin
                if (m_who == 0) m_who = e_gl ? 1 : (e_gr ? 2 : 0);
                if (frame_tick && m_who != 0) begin
                    if (m_who == 1) begin m_sl = m_sl + 1; m_dir = 0; end
                    else begin m_sr = m_sr + 1; m_dir = 1; end
                    m_freeze = 1;
                    if (m_sl == 7 || m_sr == 7) begin
                        m_mode = M_OVER; m_over = 1; m_win = (m_who == 1) ? 1 : 0;
                    end else begin
                        m_mode = M_PAUSE; m_pause = 60;
                    end
                    m_who = 0;
                end
            end else if (m_mode == M_PAUSE) begin
                if (frame_tick) begin
                    m_pause = m_pause - 1;
                    if (m_pause == 0) begin m_mode = M_PLAY; m_freeze = 0; end
                end
            end else begin
                if (e_st) begin
                    m_mode = M_IDLE; m_sl = 0; m_sr = 0; m_over = 0; m_win = 0;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            chk("cyc_score_l", 32'(score_l), 32'(m_sl));
            chk("cyc_score_r", 32'(score_r), 32'(m_sr));
            chk("cyc_ball_freeze", 32'(ball_freeze), 32'(m_freeze));
            chk("cyc_serve_dir", 32'(serve_dir), 32'(m_dir));
            chk("cyc_game_over", 32'(game_over), 32'(m_over));
            if (m_over != 0) chk("cyc_winner", 32'(winner), 32'(m_win));
        end
    end

    task automatic do_tick();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic pause_ticks(input int n);
        repeat (n) begin
            do_tick();
            @(negedge clk);
        end
    endtask

    task automatic score_left();
        goal_l = 1'b1;
        @(negedge clk);
        goal_l = 1'b0;
        @(negedge clk);
        do_tick();
    endtask

    task automatic press_start();
        start_btn = 1'b1;
        @(negedge clk);
        start_btn = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_score_l", 32'(score_l), 32'd0);
        chk("rst_score_r", 32'(score_r), 32'd0);
        chk("rst_ball_freeze", 32'(ball_freeze), 32'd1);
        chk("rst_serve_dir", 32'(serve_dir), 32'd0);
        chk("rst_game_over", 32'(game_over), 32'd0);
        chk("rst_winner", 32'(winner), 32'd0);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        repeat (2) @(negedge clk);

        // Start held for 5 cycles: one transition, freeze drops after first sample
        start_btn = 1'b1;
        @(negedge clk);
        chk("start_freeze_drop", 32'(ball_freeze), 32'd0);
        repeat (4) @(negedge clk);
        start_btn = 1'b0;
        @(negedge clk);
        chk("start_scores", {26'd0, score_l, score_r}, 32'd0);

        // Held left goal, tick 10 cycles later
        goal_l = 1'b1;
        repeat (4) @(negedge clk);
        goal_l = 1'b0;
        repeat (10) @(negedge clk);
        chk("pre_tick_score_l", 32'(score_l), 32'd0);
        do_tick();
        chk("goal1_score_l", 32'(score_l), 32'd1);
        chk("goal1_freeze", 32'(ball_freeze), 32'd1);
        chk("goal1_serve_dir", 32'(serve_dir), 32'd0);
        chk("goal1_score_r", 32'(score_r), 32'd0);
        pause_ticks(59);
        chk("pause59_freeze", 32'(ball_freeze), 32'd1);
        pause_ticks(1);
        chk("pause60_freeze", 32'(ball_freeze), 32'd0);

        // Start ignored in PLAY; simultaneous goals: left wins
        press_start();
        goal_l = 1'b1;
        goal_r = 1'b1;
        @(negedge clk);
        goal_l = 1'b0;
        goal_r = 1'b0;
        @(negedge clk);
        do_tick();
        chk("tie_score_l", 32'(score_l), 32'd2);
        chk("tie_score_r", 32'(score_r), 32'd0);

        // Right goal during pause is dropped
        pause_ticks(10);
        goal_r = 1'b1;
        @(negedge clk);
        goal_r = 1'b0;
        pause_ticks(50);
        repeat (5) @(negedge clk);
        do_tick();
        chk("pause_goal_score_r", 32'(score_r), 32'd0);
        chk("pause_goal_freeze", 32'(ball_freeze), 32'd0);

        // Left concedes up to seven
        for (int i = 3; i <= 7; i++) begin
            score_left();
            chk("run_score_l", 32'(score_l), 32'(i));
            if (i < 7) pause_ticks(60);
        end
        chk("over_game_over", 32'(game_over), 32'd1);
        chk("over_winner", 32'(winner), 32'd1);
        chk("over_freeze", 32'(ball_freeze), 32'd1);
        goal_r = 1'b1;
        @(negedge clk);
        goal_r = 1'b0;
        pause_ticks(3);
        chk("over_hold_score_r", 32'(score_r), 32'd0);

        press_start();
        chk("idle_scores", {26'd0, score_l, score_r}, 32'd0);
        chk("idle_game_over", 32'(game_over), 32'd0);
        chk("idle_freeze", 32'(ball_freeze), 32'd1);
        press_start();
        chk("replay_freeze", 32'(ball_freeze), 32'd0);

        // Right concedes three; second one with tick in the same cycle as the rise
        for (int j = 1; j <= 3; j++) begin
            goal_r = 1'b1;
            if (j == 2) frame_tick = 1'b1;
            @(negedge clk);
            goal_r = 1'b0;
            frame_tick = 1'b0;
            if (j != 2) begin
                @(negedge clk);
                do_tick();
            end
            chk("right_score_r", 32'(score_r), 32'(j));
            chk("right_serve_dir", 32'(serve_dir), 32'd1);
            if (j < 3) pause_ticks(60);
        end
        pause_ticks(5);

        // Asynchronous reset mid-pause, checked before the next clock edge
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_score_r", 32'(score_r), 32'd0);
        chk("arst_freeze", 32'(ball_freeze), 32'd1);
        chk("arst_serve_dir", 32'(serve_dir), 32'd0);
        chk("arst_game_over", 32'(game_over), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        press_start();
        chk("post_rst_play", 32'(ball_freeze), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Game-score sequencer feeding the two score-pip display counters, one per player.
- Takes goal events from the ball-physics block and a per-frame tick from the video timing generator.
- Maintains each player's conceded-goal count (0..MAX_SCORE), runs the serve pause and game-over sequencing, and freezes the ball between points.
- Score changes are applied only on frame boundaries so the pip display never tears mid-frame.

Parameters:
- MAX_SCORE, 3'd7, conceded count that ends the game; at this count the display shows zero pips.
- PAUSE_FRAMES, 8'd60, frames the ball stays frozen after a point.
- PW, 8, width of the pause frame counter; must satisfy PAUSE_FRAMES < 2^PW.

Ports:
- clk  in  1  system pixel clock
- rst_n  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle pulse at start of vertical blanking
- goal_l  in  1  ball exited left edge (left player conceded); may be held high for several cycles
- goal_r  in  1  ball exited right edge (right player conceded); may be held high for several cycles
- start_btn  in  1  start button, already synchronised and debounced, level
- score_l  out  3  left player conceded count, to left pip display
- score_r  out  3  right player conceded count, to right pip display
- ball_freeze  out  1  1 = physics holds ball at centre
- serve_dir  out  1  0 = serve toward left, 1 = serve toward right
- game_over  out  1  high while in OVER
- winner  out  1  0 = left won, 1 = right won; valid only while game_over = 1

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; score_l = score_r = 0; ball_freeze = 1; serve_dir = 0; game_over = 0; winner = 0.
  - Pause counter = 0; pending flags cleared; edge-detect registers = 0.
- Edge detection:
  - goal_l, goal_r and start_btn are rising-edge detected against a registered copy.
  - A held level counts as one event only.
- State IDLE:
  - Scores held at 0; ball_freeze = 1.
  - Start rise -> PLAY; ball_freeze = 0 from the next cycle.
- State PLAY:
  - A goal rise sets pend_l or pend_r, only if neither flag is already set.
  - Same-cycle rise on both: pend_l wins; the right event is discarded.
  - Further goal rises while a flag is pending are ignored.
  - On frame_tick with a pending flag (a tick in the same cycle as the rise counts):
    - Increment that player's score; clear the pending flag; ball_freeze = 1.
    - serve_dir = 0 if the left player conceded, 1 if the right player conceded.
    - If the new score == MAX_SCORE -> OVER; winner = the other player.
    - Otherwise -> PAUSE with counter = PAUSE_FRAMES.
    - Score and state change on the same clk edge that samples frame_tick high, giving 1-cycle latency from tick to output.
  - start_btn is ignored.
- State PAUSE:
  - Goals and start_btn are ignored; no pending flags are set.
  - Each frame_tick decrements the counter.
  - On the tick where the counter goes 1 -> 0: -> PLAY; ball_freeze = 0 on that same edge.
  - PAUSE_FRAMES = 0 is illegal.
- State OVER:
  - game_over = 1; ball_freeze = 1; scores held.
  - Start rise -> IDLE: both scores = 0, game_over = 0, winner = 0.
  - A second start rise then begins play.
- Arithmetic:
  - Scores are 3-bit unsigned and never exceed MAX_SCORE; no wrap is possible because OVER is entered at MAX_SCORE.
  - The pause counter never underflows.
- Reset mid-operation: any state returns to the reset values immediately on rst_n low.
- Outputs are all registered; no combinational path from inputs to outputs.

Decomposition:
- Shared pong package holds:
  - state encoding: IDLE = 2'd0, PLAY = 2'd1, PAUSE = 2'd2, OVER = 2'd3;
  - MAX_SCORE and PAUSE_FRAMES defaults, shared with the display controller and physics block.
- One natural sub-module: edge_detect, a single-bit registered rising-edge pulse with async active-low reset, instantiated three times.
- FSM, pending flags and counters stay in score_keeper.

Test Plan:
- Reset, then start_btn high for 5 cycles -> single transition to PLAY; ball_freeze 1 -> 0 one cycle after the first high sample; scores remain 0/0.
- In PLAY, goal_l high for 4 cycles, then frame_tick 10 cycles later:
  - score_l 0 -> 1 on the tick edge, with ball_freeze = 1 and serve_dir = 0;
  - after exactly 60 further frame_ticks, ball_freeze = 0;
  - score_r unchanged.
- goal_l and goal_r rise in the same cycle -> score_l = 1, score_r = 0 after the tick.
- goal_r pulse during PAUSE -> no score change; no extra point after the pause ends.
- Drive 7 left goals, each separated by the pause:
  - 7th tick gives score_l = 7, game_over = 1, winner = 1, ball_freeze = 1;
  - start_btn -> IDLE with 0/0 and game_over = 0;
  - second start_btn -> PLAY.
- rst_n low mid-PAUSE with score_r = 3 -> all outputs return to reset values asynchronously, before the next clk edge.
